// File: rtl/mram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mram_arb_pkg
// Description : Shared definitions for the MRAM access arbiter: FSM state
//               encoding, requester count and MRAM strobe active level.
// Revision    : 1.0 - initial release
// ============================================================================
package mram_arb_pkg;

    localparam int REQ_N = 2;

    // MRAM control strobes are active low.
    localparam logic c_strobe_act  = 1'b0;
    localparam logic c_strobe_idle = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage : mram_arb_pkg
`default_nettype wire

// File: rtl/mram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mram_access_arbiter_if
// Description : Bundles the requester handshake (req/we/addr/wdata/be ->
//               gnt/done/rdata/busy) and the MRAM pin side (address, data,
//               DQ direction, DQ input, five active-low strobes).
//               slave  : arbiter view
//               master : requester / MRAM model view
// Revision    : 1.0 - initial release
// ============================================================================
interface mram_access_arbiter_if
    import mram_arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [REQ_N-1:0]        req;
    logic [REQ_N-1:0]        we;
    logic [REQ_N*ADDR_W-1:0] addr;
    logic [REQ_N*DATA_W-1:0] wdata;
    logic [2*REQ_N-1:0]      be;
    logic [REQ_N-1:0]        gnt;
    logic [REQ_N-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;
    logic [ADDR_W-1:0]       write_addr;
    logic [DATA_W-1:0]       write_data;
    logic                    dq_oe;
    logic [DATA_W-1:0]       dq_in;
    logic                    chip_en;
    logic                    read_en;
    logic                    write_en;
    logic                    lb_en;
    logic                    ub_en;

    modport slave (
        input  req, we, addr, wdata, be, dq_in,
        output gnt, done, rdata, busy, write_addr, write_data, dq_oe,
               chip_en, read_en, write_en, lb_en, ub_en
    );

    modport master (
        output req, we, addr, wdata, be, dq_in,
        input  gnt, done, rdata, busy, write_addr, write_data, dq_oe,
               chip_en, read_en, write_en, lb_en, ub_en
    );

endinterface : mram_access_arbiter_if
`default_nettype wire

// File: rtl/mram_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : mram_phase_timer
// Description : Loadable down-counter timing the ACCESS phase. load copies
//               load_val, dec counts down and stops at zero, tc is high
//               while the count is zero.
// Ports       : clk, rst, load, load_val[WIDTH], dec -> tc
// Revision    : 1.0 - initial release
// ============================================================================
module mram_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tc = (r_cnt == '0);

endmodule : mram_phase_timer
`default_nettype wire

// File: rtl/mram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mram_access_arbiter
// Description : Shares the MRAM async port between requester 0 (I2C slave)
//               and requester 1 (local/PTS). Arbitrates, latches the winning
//               request and sequences SETUP -> ACCESS (ACC_CYC) -> HOLD.
//               gnt pulses during SETUP, done during HOLD.
// Ports       : clk, rst (sync, active high), bus (mram_access_arbiter_if.slave)
// Config      : MRAM_RR_ARB_EN - round-robin arbitration when defined,
//               otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mram_access_arbiter
    import mram_arb_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mram_access_arbiter_if.slave bus
);

    localparam int ACC_EFF = (ACC_CYC < 1) ? 1 : ACC_CYC;
    localparam int CNT_W   = (ACC_EFF > 1) ? $clog2(ACC_EFF) : 1;
    localparam logic [CNT_W-1:0] c_acc_load = CNT_W'(ACC_EFF - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_win;
    logic                w_grant;
    logic                w_tc;
    logic                w_active;
    logic [REQ_N-1:0]    w_gnt;
    logic [REQ_N-1:0]    w_done;
    logic                w_dq_oe;
    logic                w_chip_en;
    logic                w_read_en;
    logic                w_write_en;
    logic                w_lb_en;
    logic                w_ub_en;

    assign w_grant = (r_state == ST_IDLE) && (bus.req != '0);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MRAM_RR_ARB_EN
    // r_prio names the requester that wins a tie; it moves to the other
    // requester after every grant so the last winner yields next time.
    logic r_prio;

    assign w_win = (bus.req == 2'b11) ? r_prio : bus.req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_grant) begin
            r_prio <= ~w_win;
        end
    end
`else
    assign w_win = ~bus.req[0];
`endif

    // ------------------------------------------------------------------
    // Request latch and read data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_win   <= w_win;
                r_we    <= w_win ? bus.we[1] : bus.we[0];
                r_addr  <= w_win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
                r_wdata <= w_win ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
                r_be    <= w_win ? bus.be[3:2] : bus.be[1:0];
            end
            // Last ACCESS edge: strobe has been active for ACC_CYC cycles.
            if ((r_state == ST_ACCESS) && w_tc && !r_we) begin
                r_rdata <= bus.dq_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase timer and FSM
    // ------------------------------------------------------------------
    mram_phase_timer #(
        .WIDTH (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == ST_SETUP),
        .load_val (c_acc_load),
        .dec      (r_state == ST_ACCESS),
        .tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.req != '0) w_state_next = ST_SETUP;
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: if (w_tc) w_state_next = ST_HOLD;
            ST_HOLD:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe decode. A request with no byte enabled runs the full
    // sequence for timing but never selects the chip.
    // ------------------------------------------------------------------
    assign w_active = (r_be != 2'b00);

    always_comb begin
        w_gnt      = '0;
        w_done     = '0;
        w_dq_oe    = 1'b0;
        w_chip_en  = c_strobe_idle;
        w_read_en  = c_strobe_idle;
        w_write_en = c_strobe_idle;
        w_lb_en    = c_strobe_idle;
        w_ub_en    = c_strobe_idle;
        if (r_state != ST_IDLE) begin
            w_dq_oe = r_we;
            if (w_active) begin
                w_chip_en = c_strobe_act;
                w_lb_en   = r_be[0] ? c_strobe_act : c_strobe_idle;
                w_ub_en   = r_be[1] ? c_strobe_act : c_strobe_idle;
            end
        end
        unique case (r_state)
            ST_SETUP:  w_gnt[r_win] = 1'b1;
            ST_ACCESS: begin
                if (w_active) begin
                    if (r_we) w_write_en = c_strobe_act;
                    else      w_read_en  = c_strobe_act;
                end
            end
            ST_HOLD:   w_done[r_win] = 1'b1;
            default:   ;
        endcase
    end

    assign bus.gnt        = w_gnt;
    assign bus.done       = w_done;
    assign bus.rdata      = r_rdata;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.write_addr = r_addr;
    assign bus.write_data = r_wdata;
    assign bus.dq_oe      = w_dq_oe;
    assign bus.chip_en    = w_chip_en;
    assign bus.read_en    = w_read_en;
    assign bus.write_en   = w_write_en;
    assign bus.lb_en      = w_lb_en;
    assign bus.ub_en      = w_ub_en;

endmodule : mram_access_arbiter
`default_nettype wire

// File: tb/tb_mram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mram_access_arbiter
// Description : Self-checking bench for mram_access_arbiter. A transaction
//               timeline model predicts every output each cycle; a table of
//               single accesses plus hand sequences check arbitration, burst
//               period, byte enables, reset mid-access and address range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mram_access_arbiter;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int ACC   = 2;
    localparam int ACC_E = (ACC < 1) ? 1 : ACC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mram_access_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ACC_CYC (ACC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: position within the current transaction
    // (0 = idle, 1 = setup, 2..ACC_E+1 = access, ACC_E+2 = hold).
    // ------------------------------------------------------------------
    int          m_pos   = 0;
    int          m_win   = 0;
    int          m_last  = 1;   // last granted requester
    logic        m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]  m_be    = 2'b00;

    task automatic model_advance();
        int w;
        if (rst) begin
            m_pos = 0; m_win = 0; m_last = 1; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = 2'b00;
        end else if (m_pos == 0) begin
            if (bus.req != 2'b00) begin
`ifdef MRAM_RR_ARB_EN
                if (bus.req == 2'b11) w = 1 - m_last;
                else                  w = bus.req[0] ? 0 : 1;
`else
                w = bus.req[0] ? 0 : 1;
`endif
                m_last  = w;
                m_win   = w;
                m_we    = bus.we[w];
                m_addr  = bus.addr[w*AW +: AW];
                m_wdata = bus.wdata[w*DW +: DW];
                m_be    = bus.be[2*w +: 2];
                m_pos   = 1;
            end
        end else if (m_pos == ACC_E + 2) begin
            m_pos = 0;
        end else begin
            if ((m_pos == ACC_E + 1) && !m_we) m_rdata = bus.dq_in;
            m_pos++;
        end
    endtask

    function automatic logic [63:0] model_out();
        logic act, acc, busy;
        logic [1:0] g, d;
        busy = (m_pos != 0);
        act  = busy && (m_be != 2'b00);
        acc  = (m_pos >= 2) && (m_pos <= ACC_E + 1);
        g    = (m_pos == 1) ? 2'(1 << m_win) : 2'b00;
        d    = (m_pos == ACC_E + 2) ? 2'(1 << m_win) : 2'b00;
        return {1'b0, g, d, m_rdata, busy, m_addr, m_wdata, busy && m_we,
                !act, !(act && acc && !m_we), !(act && acc && m_we),
                !(act && m_be[0]), !(act && m_be[1])};
    endfunction

    function automatic logic [63:0] dut_out();
        return {1'b0, bus.gnt, bus.done, bus.rdata, bus.busy, bus.write_addr,
                bus.write_data, bus.dq_oe, bus.chip_en, bus.read_en,
                bus.write_en, bus.lb_en, bus.ub_en};
    endfunction

    // Inputs are set before calling; the model predicts the next edge,
    // outputs are compared on the following falling edge.
    task automatic step();
        model_advance();
        @(negedge clk);
        chk("cycle", dut_out(), model_out());
    endtask

    // ------------------------------------------------------------------
    // Directed single-access table
    // ------------------------------------------------------------------
    typedef struct {
        int          rq;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]  be;
        logic [DW-1:0] dq;
        int          ce_n;
        int          we_n;
        int          re_n;
        logic        ub;
        logic        lb;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tab[5];

    task automatic run_vec(input vec_t v);
        int gc, dc, cce, cwe, cre;
        logic sub, slb;
        logic [AW-1:0] ga;
        logic [DW-1:0] rd;
        gc = -1; dc = -1; cce = 0; cwe = 0; cre = 0; sub = 0; slb = 0;
        ga = '0; rd = '0;
        bus.req = 2'b00;
        bus.req[v.rq] = 1'b1;
        bus.we[v.rq] = v.we;
        bus.addr[v.rq*AW +: AW] = v.addr;
        bus.wdata[v.rq*DW +: DW] = v.wdata;
        bus.be[2*v.rq +: 2] = v.be;
        bus.dq_in = v.dq;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.gnt[v.rq] && gc < 0) begin gc = c; ga = bus.write_addr; end
            if (!bus.chip_en)  cce++;
            if (!bus.write_en) cwe++;
            if (!bus.read_en)  cre++;
            if (!bus.ub_en) sub = 1'b1;
            if (!bus.lb_en) slb = 1'b1;
            if (bus.done[v.rq]) begin dc = c; rd = bus.rdata; break; end
        end
        bus.req = 2'b00;
        step();
        chk("gnt_cycle",  64'(gc), 64'(1));
        chk("done_cycle", 64'(dc), 64'(ACC_E + 2));
        chk("addr",       64'(ga), 64'(v.addr));
        chk("ce_cycles",  64'(cce), 64'(v.ce_n));
        chk("we_cycles",  64'(cwe), 64'(v.we_n));
        chk("re_cycles",  64'(cre), 64'(v.re_n));
        chk("ub_lb",      64'({sub, slb}), 64'({v.ub, v.lb}));
        chk("rdata",      64'(rd), 64'(v.rdata));
    endtask

    initial begin
        int wins[3];
        int gcyc[3];
        int k;
        logic [DW-1:0] hold_rd;

        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        bus.be = '0; bus.dq_in = '0;

        // T1 write, T2 read, T4 byte enables, full-range address read
        tab[0] = '{0, 1'b1, 20'h12345, 16'hBEEF, 2'b11, 16'h0000, ACC_E+2, ACC_E, 0, 1'b1, 1'b1, 16'h0000};
        tab[1] = '{1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hA5C3, ACC_E+2, 0, ACC_E, 1'b1, 1'b1, 16'hA5C3};
        tab[2] = '{0, 1'b1, 20'h0ABCD, 16'h1357, 2'b10, 16'h0000, ACC_E+2, ACC_E, 0, 1'b1, 1'b0, 16'hA5C3};
        tab[3] = '{1, 1'b1, 20'h00777, 16'h2468, 2'b00, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 16'hA5C3};
        tab[4] = '{0, 1'b0, 20'hFFFFF, 16'h0000, 2'b01, 16'h1234, ACC_E+2, 0, ACC_E, 1'b0, 1'b1, 16'h1234};

        step(); step();
        chk("reset_state", dut_out(), {1'b0, 2'b00, 2'b00, 16'h0, 1'b0, 20'h0, 16'h0, 1'b0, 5'b11111});
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(tab[i]);

        // rdata held while idle after the last read
        hold_rd = bus.rdata;
        bus.dq_in = 16'h5555;
        step(); step();
        chk("rdata_hold", 64'(bus.rdata), 64'(16'h1234));

        // T3: both requesting for two accesses
        rst = 1'b1; step(); rst = 1'b0;
        bus.we = 2'b11; bus.be = 4'hF;
        bus.addr = {20'h22222, 20'h11111};
        bus.wdata = {16'hB0B0, 16'hA0A0};
        bus.req = 2'b11;
        k = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (bus.gnt != 2'b00 && k < 2) begin
                wins[k] = bus.gnt[1] ? 1 : 0; gcyc[k] = c; k++;
            end
            if (bus.done != 2'b00 && k == 2) break;
        end
        bus.req = 2'b00;
        step();
        chk("t3_count", 64'(k), 64'(2));
        chk("t3_win0", 64'(wins[0]), 64'(0));
`ifdef MRAM_RR_ARB_EN
        chk("t3_win1", 64'(wins[1]), 64'(1));
`else
        chk("t3_win1", 64'(wins[1]), 64'(0));
`endif
        chk("t3_period", 64'(gcyc[1] - gcyc[0]), 64'(ACC_E + 3));

        // T6: burst at top address
        bus.we = 2'b00; bus.be = 4'hF;
        bus.addr = {20'h00000, 20'hFFFFF};
        bus.req = 2'b01;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.dq_in = 16'($urandom);
            step();
            if (bus.gnt[0] && k < 3) begin
                gcyc[k] = c; k++;
                chk("t6_addr", 64'(bus.write_addr), 64'(20'hFFFFF));
            end
            if (bus.done[0] && k == 3) break;
        end
        bus.req = 2'b00;
        step();
        chk("t6_count", 64'(k), 64'(3));
        chk("t6_period", 64'(gcyc[2] - gcyc[1]), 64'(ACC_E + 3));

        // T5: reset during ACCESS with request held
        bus.we = 2'b01; bus.wdata = {16'h0, 16'hCAFE}; bus.addr = {20'h0, 20'h00042};
        bus.req = 2'b01;
        step(); step();
        chk("t5_in_access", 64'({bus.busy, bus.write_en}), 64'(2'b10));
        rst = 1'b1;
        step();
        chk("t5_after_rst", 64'({bus.busy, bus.dq_oe, bus.done, bus.chip_en, bus.read_en,
                                 bus.write_en, bus.lb_en, bus.ub_en}), 64'(9'b0_0_00_11111));
        rst = 1'b0;
        step();
        chk("t5_regrant", 64'(bus.gnt), 64'(2'b01));
        k = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (bus.done[0]) begin k = 1; break; end
        end
        bus.req = 2'b00;
        step();
        chk("t5_done", 64'(k), 64'(1));

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.req   = 2'($urandom_range(0, 3));
            bus.we    = 2'($urandom);
            bus.addr  = 40'({$urandom(), $urandom()});
            bus.wdata = 32'($urandom);
            bus.be    = 4'($urandom);
            bus.dq_in = 16'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; bus.req = 2'b00;
        step(); step(); step(); step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mram_access_arbiter
`default_nettype wire
